// File: rtl/famipad_pkg.sv
// Shared types and constants for the Famiclone/NES serial gamepad reader.
// The FAMIPAD_FILTER_EN glitch filter is configured in famipad_reader.
package famipad_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int LATCH_TICKS = 2;
  localparam int NBITS       = 8;

  // Released buttons read high, so an absent pad and the reset value agree.
  localparam logic [NBITS-1:0] PAD_IDLE = 8'hFF;

endpackage

// File: rtl/famipad_tick_gen.sv
// Free-running divider: one-cycle tick strobe every TICK_DIV clocks.
module famipad_tick_gen #(
  parameter int TICK_DIV = 300
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/famipad_reader.sv
// Initiator for the NES serial pad: drives LATCH/PULSE, shifts in 8 bits, publishes via ready/ack.
// Optional FAMIPAD_FILTER_EN: publish only when two consecutive frames agree.
module famipad_reader
  import famipad_pkg::*;
#(
  parameter int TICK_DIV   = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ser_data_in,
  output logic             ser_latch_out,
  output logic             ser_pulse_out,
  output logic [NBITS-1:0] pad_data,
  output logic             pad_ready,
  input  logic             pad_ack,
  output logic             pad_overrun,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshake: pad_ready is a level that stays high until a pad_ack strobe is seen while
  // it is high; a publish in the same cycle as pad_ack wins and leaves pad_ready set.

  localparam int PW  = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam int LCW = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
  localparam int BW  = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PW-1:0]  POLL_RELOAD = PW'(POLL_TICKS - 1);
  localparam logic [LCW-1:0] LATCH_LAST  = LCW'(LATCH_TICKS - 1);
  localparam logic [BW-1:0]  BIT_LAST    = BW'(NBITS - 1);

  logic tick;

  famipad_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .tick  (tick)
  );

  // Pad line is asynchronous to CLOCK_50; idles high like the pull-up.
  logic data_s1, data_sync;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_s1   <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_s1   <= ser_data_in;
      data_sync <= data_s1;
    end
  end

  state_t           state, state_nxt;
  logic [PW-1:0]    poll_cnt, poll_nxt;
  logic [LCW-1:0]   latch_cnt, latch_cnt_nxt;
  logic [BW-1:0]    bit_idx, bit_idx_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt;
  logic             publish;
  logic             publish_ok;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      poll_cnt  <= '0;
      latch_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= PAD_IDLE;
    end else begin
      state     <= state_nxt;
      poll_cnt  <= poll_nxt;
      latch_cnt <= latch_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    poll_nxt      = poll_cnt;
    latch_cnt_nxt = latch_cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    publish       = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (poll_cnt != '0) begin
            poll_nxt = poll_cnt - 1'b1;
          end else if (enable) begin
            state_nxt     = LATCH;
            latch_cnt_nxt = '0;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          if (latch_cnt == LATCH_LAST) begin
            state_nxt   = LOW;
            bit_idx_nxt = '0;
          end else begin
            latch_cnt_nxt = latch_cnt + 1'b1;
          end
        end
      end
      LOW: begin
        // The pad has held this bit since LATCH fell or the previous PULSE rose.
        if (tick) begin
          shreg_nxt = {shreg[NBITS-2:0], data_sync};
          state_nxt = (bit_idx == BIT_LAST) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          bit_idx_nxt = bit_idx + 1'b1;
          state_nxt   = LOW;
        end
      end
      DONE: begin
        publish   = 1'b1;
        poll_nxt  = POLL_RELOAD;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Lines are registered from the next state so GPIO never sees decode glitches.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ser_latch_out <= 1'b0;
      ser_pulse_out <= 1'b0;
      busy          <= 1'b0;
    end else begin
      ser_latch_out <= (state_nxt == LATCH);
      ser_pulse_out <= (state_nxt == HIGH);
      busy          <= (state_nxt == LATCH) || (state_nxt == LOW) || (state_nxt == HIGH);
    end
  end

`ifdef FAMIPAD_FILTER_EN
  logic [NBITS-1:0] cand;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cand <= PAD_IDLE;
    end else if (publish) begin
      cand <= shreg;
    end
  end

  assign publish_ok = (shreg == cand);
`else
  assign publish_ok = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pad_data    <= PAD_IDLE;
      pad_ready   <= 1'b0;
      pad_overrun <= 1'b0;
    end else if (publish && publish_ok) begin
      pad_data    <= shreg;
      pad_ready   <= 1'b1;
      pad_overrun <= pad_ack ? 1'b0 : (pad_overrun | pad_ready);
    end else if (pad_ack && pad_ready) begin
      pad_ready   <= 1'b0;
      pad_overrun <= 1'b0;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_famipad_reader.sv
// Self-checking bench for famipad_reader with a behavioural shift-register pad model.
module tb_famipad_reader;
  import famipad_pkg::*;

  localparam int TD   = 4;
  localparam int POLL = 3;
  localparam int FRAME_TICKS = LATCH_TICKS + 2 * NBITS - 1;
  localparam int PERIOD = (FRAME_TICKS + POLL) * TD;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       ser_data_in;
  logic       latch;
  logic       pulse;
  logic [7:0] pad_data;
  logic       pad_ready;
  logic       pad_ack;
  logic       pad_overrun;
  logic       busy;
  state_t     dbg_state;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  famipad_reader #(
    .TICK_DIV   (TD),
    .POLL_TICKS (POLL)
  ) dut (
    .CLOCK_50      (clk),
    .reset_n       (rst_n),
    .enable        (enable),
    .ser_data_in   (ser_data_in),
    .ser_latch_out (latch),
    .ser_pulse_out (pulse),
    .pad_data      (pad_data),
    .pad_ready     (pad_ready),
    .pad_ack       (pad_ack),
    .pad_overrun   (pad_overrun),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: LATCH reloads, each PULSE rise advances to the next button; stream[k] is k-th bit sent.
  logic [7:0] pad_stream = 8'hFF;
  logic       pad_present = 1'b1;
  int         pad_idx = 0;

  always @(posedge pulse or posedge latch) begin
    if (latch) pad_idx = 0;
    else       pad_idx = pad_idx + 1;
  end

  assign ser_data_in = !pad_present ? 1'b1 :
                       ((pad_idx < 8) ? pad_stream[pad_idx[2:0]] : 1'b0);

  // Reader places the first bit received in the MSB.
  function automatic logic [7:0] expected_byte(input logic [7:0] stream);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = stream[k];
    return b;
  endfunction

  function automatic logic [7:0] stream_for(input logic [7:0] b);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) s[k] = b[7-k];
    return s;
  endfunction

  // driver tasks
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    pad_ack = 1'b1;
    clk_step();
    pad_ack = 1'b0;
  endtask

  // Returns in the cycle after busy falls (the publish decision cycle).
  task automatic wait_done();
    bit seen = 1'b0;
    bit ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      clk_step();
      if (busy) seen = 1'b1;
      else if (seen) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_done: busy never completed a frame within 1000 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; pad_ack = 1'b0;
    repeat (3) clk_step();
    checks++; if (latch !== 1'b0) $display("FAIL reset_latch: got %b want 0", latch); else passed++;
    checks++; if (pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", pulse); else passed++;
    checks++; if (pad_data !== 8'hFF) $display("FAIL reset_data: got %h want ff", pad_data); else passed++;
    checks++; if (pad_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", pad_ready); else passed++;
    checks++; if (pad_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", pad_overrun); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dbg_state); else passed++;
  endtask

  // First frame: LATCH 2 ticks, 7 PULSEs of one tick, 17 ticks busy, byte one cycle after busy falls.
  task automatic test_frame_timing();
    int n = 0, rise = -1, ready_at = -1;
    int latch_hi = 0, pulse_hi = 0, pulses = 0, busy_hi = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] exp;
    pad_present = 1'b1;
    pad_stream = 8'b1111_1110;
    exp = expected_byte(pad_stream);
    enable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      clk_step();
      n++;
      if (latch && rise < 0) rise = n;
      if (latch) latch_hi++;
      if (pulse) pulse_hi++;
      if (pulse && !prev_pulse) pulses++;
      if (busy) busy_hi++;
      prev_pulse = pulse;
      if (pad_ready) begin ready_at = n; break; end
    end
    checks++; if (rise !== TD) $display("FAIL first_latch: got cycle %0d want %0d", rise, TD); else passed++;
    checks++; if (latch_hi !== LATCH_TICKS * TD) $display("FAIL latch_width: got %0d want %0d", latch_hi, LATCH_TICKS * TD); else passed++;
    checks++; if (pulses !== NBITS - 1) $display("FAIL pulse_count: got %0d want %0d", pulses, NBITS - 1); else passed++;
    checks++; if (pulse_hi !== (NBITS - 1) * TD) $display("FAIL pulse_width: got %0d want %0d", pulse_hi, (NBITS - 1) * TD); else passed++;
    checks++; if (busy_hi !== FRAME_TICKS * TD) $display("FAIL busy_width: got %0d want %0d", busy_hi, FRAME_TICKS * TD); else passed++;
    checks++; if (ready_at - rise !== FRAME_TICKS * TD + 1) $display("FAIL ready_latency: got %0d want %0d", ready_at - rise, FRAME_TICKS * TD + 1); else passed++;
    checks++; if (pad_data !== exp || exp !== 8'h7F) $display("FAIL frame_data: got %h want %h", pad_data, exp); else passed++;
    ack_pulse();
    checks++; if (pad_ready !== 1'b0) $display("FAIL frame_ack: ready got %b want 0", pad_ready); else passed++;
  endtask

  task automatic test_no_pad();
    int n = 0, last = -1, rises = 0;
    pad_present = 1'b0;
    for (int i = 0; i < 4 * PERIOD && rises < 3; i++) begin
      clk_step();
      n++;
      if (pad_ready) begin
        checks++; if (pad_data !== 8'hFF) $display("FAIL nopad_data: got %h want ff", pad_data); else passed++;
        if (last >= 0) begin
          checks++; if (n - last !== PERIOD) $display("FAIL nopad_period: got %0d want %0d", n - last, PERIOD); else passed++;
        end
        last = n;
        rises++;
        ack_pulse();
        n++;
      end
    end
    checks++; if (rises !== 3) $display("FAIL nopad_count: got %0d publishes want 3", rises); else passed++;
    pad_present = 1'b1;
  endtask

  task automatic test_random_frames();
    logic [7:0] exp;
    for (int f = 0; f < 6; f++) begin
      pad_stream = 8'($urandom_range(0, 255));
      exp_q.push_back(expected_byte(pad_stream));
      wait_done();
      clk_step();
      exp = exp_q.pop_front();
      checks++; if (pad_data !== exp) $display("FAIL rand_data[%0d]: got %h want %h", f, pad_data, exp); else passed++;
      checks++; if (pad_ready !== 1'b1 || pad_overrun !== 1'b0) $display("FAIL rand_flags[%0d]: ready %b ovr %b want 1 0", f, pad_ready, pad_overrun); else passed++;
      ack_pulse();
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    pad_stream = 8'($urandom_range(0, 255));
    exp_q.push_back(expected_byte(pad_stream));
    wait_done(); clk_step();
    exp = exp_q.pop_front();
    checks++; if (pad_data !== exp || pad_overrun !== 1'b0) $display("FAIL ovr_first: data %h ovr %b want %h 0", pad_data, pad_overrun, exp); else passed++;
    pad_stream = 8'($urandom_range(0, 255));
    exp_q.push_back(expected_byte(pad_stream));
    wait_done(); clk_step();
    exp = exp_q.pop_front();
    checks++; if (pad_data !== exp) $display("FAIL ovr_data: got %h want %h", pad_data, exp); else passed++;
    checks++; if (pad_overrun !== 1'b1 || pad_ready !== 1'b1) $display("FAIL ovr_set: ovr %b ready %b want 1 1", pad_overrun, pad_ready); else passed++;
    ack_pulse();
    checks++; if (pad_overrun !== 1'b0 || pad_ready !== 1'b0) $display("FAIL ovr_clear: ovr %b ready %b want 0 0", pad_overrun, pad_ready); else passed++;
    ack_pulse();
    checks++; if (pad_ready !== 1'b0 || pad_data !== exp) $display("FAIL idle_ack: ready %b data %h want 0 %h", pad_ready, pad_data, exp); else passed++;
  endtask

  task automatic test_ack_in_done();
    logic [7:0] exp;
    pad_stream = 8'($urandom_range(0, 255));
    wait_done(); clk_step();
    pad_stream = 8'($urandom_range(0, 255));
    exp_q.push_back(expected_byte(pad_stream));
    wait_done();
    pad_ack = 1'b1;
    clk_step();
    pad_ack = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (pad_ready !== 1'b1) $display("FAIL done_ack_ready: got %b want 1", pad_ready); else passed++;
    checks++; if (pad_overrun !== 1'b0) $display("FAIL done_ack_ovr: got %b want 0", pad_overrun); else passed++;
    checks++; if (pad_data !== exp) $display("FAIL done_ack_data: got %h want %h", pad_data, exp); else passed++;
    ack_pulse();
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0, rises = 0;
    logic prev_pulse = 1'b0;
    logic [7:0] exp;
    pad_stream = 8'($urandom_range(0, 255));
    exp = expected_byte(pad_stream);
    for (int i = 0; i < 2 * PERIOD && pulses < 4; i++) begin
      clk_step();
      if (pulse && !prev_pulse) pulses++;
      prev_pulse = pulse;
    end
    clk_step();
    checks++; if (pulse !== 1'b1) $display("FAIL mid_pulse_pre: got %b want 1", pulse); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (latch !== 1'b0 || pulse !== 1'b0 || busy !== 1'b0) $display("FAIL mid_lines: latch %b pulse %b busy %b want 0 0 0", latch, pulse, busy); else passed++;
    checks++; if (pad_data !== 8'hFF || pad_ready !== 1'b0) $display("FAIL mid_outputs: data %h ready %b want ff 0", pad_data, pad_ready); else passed++;
    repeat (2) clk_step();
    rst_n = 1'b1;
    for (int i = 0; i < 4 * TD && !latch; i++) clk_step();
    enable = 1'b0;
    checks++; if (latch !== 1'b1) $display("FAIL restart_latch: got %b want 1", latch); else passed++;
    wait_done(); clk_step();
    checks++; if (pad_ready !== 1'b1 || pad_data !== exp) $display("FAIL disable_finish: ready %b data %h want 1 %h", pad_ready, pad_data, exp); else passed++;
    ack_pulse();
    for (int i = 0; i < 3 * PERIOD; i++) begin
      clk_step();
      if (latch) rises++;
    end
    checks++; if (rises !== 0) $display("FAIL disable_hold: got %0d latch cycles want 0", rises); else passed++;
  endtask

  task automatic test_filter();
    logic [7:0] frames [3];
    frames[0] = 8'hFE; frames[1] = 8'hFD; frames[2] = 8'hFD;
    rst_n = 1'b0; enable = 1'b1; pad_ack = 1'b0;
    repeat (2) clk_step();
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      pad_stream = stream_for(frames[f]);
      wait_done(); clk_step();
      if (f < 2) begin
        checks++; if (pad_ready !== 1'b0 || pad_data !== 8'hFF) $display("FAIL filter_hold[%0d]: ready %b data %h want 0 ff", f, pad_ready, pad_data); else passed++;
      end else begin
        checks++; if (pad_ready !== 1'b1 || pad_data !== 8'hFD) $display("FAIL filter_pub: ready %b data %h want 1 fd", pad_ready, pad_data); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
`ifdef FAMIPAD_FILTER_EN
    test_filter();
`else
    test_frame_timing();
    test_no_pad();
    test_random_frames();
    test_overrun();
    test_ack_in_done();
    test_reset_mid_frame();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
